// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   // ALU operation class chosen by the FSM; NONE yields an all-zero control word
   typedef enum logic [1:0] {
      AOP_NONE  = 2'd0,
      AOP_ADD   = 2'd1,
      AOP_SUB   = 2'd2,
      AOP_FUNCT = 2'd3
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_4     = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: FSM-selected operation class plus funct field
// to the 4-bit alucontrol word.
module mc_aludec
   import mc_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [3:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_AND;
      case (aluop)
         AOP_ADD: alucontrol = ALU_ADD;
         AOP_SUB: alucontrol = ALU_SUB;
         AOP_FUNCT: begin
            case (funct)
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;  // FN_ADD and unknown funct
            endcase
         end
         default: alucontrol = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM. Outputs are a function of state
// (plus mem_ready/zero handshakes) and are forced low while reset is held.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] alucontrol,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_q, state_d;
   logic   is_sw_q;
   aluop_t aluop;

   // lw/sw distinction is captured in DECODE so op is not looked at in MEMADR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         is_sw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            is_sw_q <= (op == OP_SW);
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_B;
      pcsrc      = PCSRC_ALU;
      aluop      = AOP_NONE;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = SRCB_4;
            aluop   = AOP_ADD;
            irwrite = mem_ready;
            pcen    = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMMSH;
            aluop   = AOP_ADD;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = AOP_ADD;
            state_d = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            state_d  = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = AOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = AOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            pcen    = zero;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = AOP_ADD;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = PCSRC_JUMP;
            pcen  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      // reset held: silence everything, including an in-flight access
      if (!rst_n) begin
         mem_req    = 1'b0;
         iord       = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         pcen       = 1'b0;
         regwrite   = 1'b0;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = SRCB_B;
         pcsrc      = PCSRC_ALU;
         aluop      = AOP_NONE;
         illegal_op = 1'b0;
      end
   end

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through
// the FSM and compares state plus a packed output word every cycle.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       mem_req, iord, memwrite, irwrite, pcen;
   logic       regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol, state;
   logic       illegal_op;
   logic [17:0] outs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
      .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
   );

   assign outs = {mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst,
                  memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal_op};

   function automatic logic [17:0] mk(input logic mr, io, mw, ir, pe, rw, rd, mt, sa,
                                      input logic [1:0] sb, ps,
                                      input logic [3:0] ac, input logic il);
      return {mr, io, mw, ir, pe, rw, rd, mt, sa, sb, ps, ac, il};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // compare the current cycle then advance one clock
   task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] ex);
      #2;
      chk({tag, " state"}, {28'd0, state}, {28'd0, st});
      chk({tag, " outs"}, {14'd0, outs}, {14'd0, ex});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      logic [17:0] f_rdy, f_wait, dec, dec_ill, madr, mrd, mwb, mwr;
      logic [17:0] ex_sub, ex_slt, awb, br1, br0, aiwb, jmp;
      f_rdy   = mk(1,0,0,1,1,0,0,0,0,2'b01,2'b00,4'b0010,0);
      f_wait  = mk(1,0,0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0);
      dec     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0);
      dec_ill = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,1);
      madr    = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0);
      mrd     = mk(1,1,0,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0);
      mwb     = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,0);
      mwr     = mk(1,1,1,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0);
      ex_sub  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0110,0);
      ex_slt  = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0111,0);
      awb     = mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,4'b0000,0);
      br1     = mk(0,0,0,0,1,0,0,0,1,2'b00,2'b01,4'b0110,0);
      br0     = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,0);
      aiwb    = mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,0);
      jmp     = mk(0,0,0,0,1,0,0,0,0,2'b00,2'b10,4'b0000,0);

      rst_n = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      chk("rst state", {28'd0, state}, 32'd0);
      chk("rst outs", {14'd0, outs}, 32'd0);
      #1 rst_n = 1'b1;

      // lw, zero wait; op changed in MEMADR must not matter
      cyc("lw f", 4'd0, f_rdy);
      cyc("lw d", 4'd1, dec);
      op = 6'b000000;
      cyc("lw a", 4'd2, madr);
      cyc("lw r", 4'd3, mrd);
      cyc("lw wb", 4'd4, mwb);

      // R-type SUB then SLT
      op = 6'b000000; funct = 6'b100010;
      cyc("sub f", 4'd0, f_rdy);
      cyc("sub d", 4'd1, dec);
      cyc("sub ex", 4'd6, ex_sub);
      funct = 6'b100000;
      cyc("sub wb", 4'd7, awb);
      funct = 6'b101010;
      cyc("slt f", 4'd0, f_rdy);
      cyc("slt d", 4'd1, dec);
      cyc("slt ex", 4'd6, ex_slt);
      cyc("slt wb", 4'd7, awb);

      // beq taken / not taken
      op = 6'b000100; zero = 1'b1;
      cyc("beq1 f", 4'd0, f_rdy);
      cyc("beq1 d", 4'd1, dec);
      cyc("beq1 br", 4'd8, br1);
      zero = 1'b0;
      cyc("beq0 f", 4'd0, f_rdy);
      cyc("beq0 d", 4'd1, dec);
      cyc("beq0 br", 4'd8, br0);

      // sw with a fetch stall and three MEMWR wait cycles
      op = 6'b101011; mem_ready = 1'b0;
      cyc("sw fwait", 4'd0, f_wait);
      mem_ready = 1'b1;
      cyc("sw f", 4'd0, f_rdy);
      cyc("sw d", 4'd1, dec);
      op = 6'b100011;
      cyc("sw a", 4'd2, madr);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("sw wait", 4'd5, mwr);
      mem_ready = 1'b1;
      cyc("sw w4", 4'd5, mwr);

      // addi and j
      op = 6'b001000;
      cyc("addi f", 4'd0, f_rdy);
      cyc("addi d", 4'd1, dec);
      cyc("addi ex", 4'd9, madr);
      cyc("addi wb", 4'd10, aiwb);
      op = 6'b000010;
      cyc("j f", 4'd0, f_rdy);
      cyc("j d", 4'd1, dec);
      cyc("j j", 4'd11, jmp);

      // unsupported opcode
      op = 6'b111111;
      cyc("ill f", 4'd0, f_rdy);
      cyc("ill d", 4'd1, dec_ill);
      op = 6'b100011;
      cyc("ill next", 4'd0, f_rdy);

      // reset asserted in the middle of a stalled load
      cyc("rlw d", 4'd1, dec);
      cyc("rlw a", 4'd2, madr);
      mem_ready = 1'b0;
      cyc("rlw r", 4'd3, mrd);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst state", {28'd0, state}, 32'd0);
      chk("midrst outs", {14'd0, outs}, 32'd0);
      @(posedge clk);
      #2;
      chk("rsthold outs", {14'd0, outs}, 32'd0);
      mem_ready = 1'b1;
      #1 rst_n = 1'b1;
      #1;
      chk("rel state", {28'd0, state}, 32'd0);
      chk("rel outs", {14'd0, outs}, {14'd0, f_rdy});
      @(posedge clk);
      #3;
      chk("rel next", {28'd0, state}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 No parameters; all encodings come from mc_ctrl_pkg.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  6  instruction opcode, from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 iord  output  1  0 = PC addresses memory; 1 = ALUOut addresses memory.
REQ-010 memwrite  output  1  memory write strobe.
REQ-011 irwrite  output  1  instruction register load.
REQ-012 pcen  output  1  PC load enable.
REQ-013 regwrite, regdst, memtoreg  output  1 each  register-file write, destination select and write-back select.
REQ-014 alusrca  output  1  0 = PC; 1 = register A.
REQ-015 alusrcb  output  2  00 = B; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate << 2.
REQ-016 pcsrc  output  2  00 = ALU result; 01 = ALUOut; 10 = jump target.
REQ-017 alucontrol  output  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
REQ-018 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-019 state  output  4  current FSM state, for debug.

Function
REQ-020 Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-021 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
REQ-022 FETCH: irwrite and pcen SHALL be asserted only when mem_ready=1; FETCH -> DECODE on mem_ready, otherwise hold.
REQ-023 DECODE: alusrca=0, alusrcb=11, ADD.
REQ-024 DECODE branches on op: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other op -> FETCH with illegal_op=1 for that cycle.
REQ-025 MEMADR: alusrca=1, alusrcb=10, ADD; next state MEMRD for lw, MEMWR for sw.
REQ-026 MEMRD: mem_req=1, iord=1; hold until mem_ready, then -> MEMWB.
REQ-027 MEMWR: mem_req=1, iord=1, memwrite=1; hold until mem_ready, then -> FETCH.
REQ-028 MEMWB: regwrite=1, memtoreg=1, regdst=0; -> FETCH.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other funct ADD; -> ALUWB.
REQ-030 ALUWB: regwrite=1, regdst=1, memtoreg=0; -> FETCH.
REQ-031 BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero; -> FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, ADD; -> ADDIWB.
REQ-033 ADDIWB: regwrite=1, regdst=0, memtoreg=0; -> FETCH.
REQ-034 JUMP: pcsrc=10, pcen=1; -> FETCH.
REQ-035 Any output not listed for a state SHALL be 0.
REQ-036 Zero-wait latency in cycles, including FETCH: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5; each mem_ready=0 cycle adds one.
REQ-037 op and funct SHALL be sampled only in DECODE and EXECUTE; changes in other states SHALL have no effect.

Reset
REQ-038 rst_n low SHALL force state to FETCH asynchronously and drive every output to 0 while held, regardless of the current state, including mid-access.
REQ-039 On the first rising edge after rst_n rises, the FSM SHALL be in FETCH and respond normally; no pending memory access is resumed.

Structure
REQ-040 mc_ctrl_pkg SHALL hold the state enum, opcode/funct constants, the alucontrol codes and the alusrcb/pcsrc encodings.
REQ-041 A single sub-module mc_aludec SHALL be combinational and map (state-selected aluop, funct) to alucontrol; the FSM SHALL be in mc_controller.

Verification
REQ-042 Reset low mid-MEMRD -> state=0 and all outputs 0 immediately; release -> FETCH with mem_req=1.
REQ-043 lw, mem_ready always 1 -> states 0,1,2,3,4 then 0; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-044 R-type funct 100010, then 101010 -> alucontrol 0110 then 0111 in EXECUTE; ALUWB regdst=1.
REQ-045 beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; same instruction with zero=0 -> pcen=0.
REQ-046 sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 held 4 cycles; then FETCH.
REQ-047 op=111111 -> illegal_op=1 for one cycle in DECODE; next state FETCH; regwrite and memwrite never asserted.
